// File: rtl/axi_hier_throttle.sv
`default_nettype none
// ============================================================================
// Module   : axi_hier_throttle
// Purpose  : Per-port AXI outstanding-transaction limiter with quiesce/idle.
// Revision : 1.0 - initial release
// ============================================================================

package axi_hier_throttle_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_t;

    typedef struct packed {
        ax_t  aw;
        logic aw_valid;
        w_t   w;
        logic w_valid;
        logic b_ready;
        ax_t  ar;
        logic ar_valid;
        logic r_ready;
    } req_t;

    typedef struct packed {
        logic aw_ready;
        logic ar_ready;
        logic w_ready;
        b_t   b;
        logic b_valid;
        r_t   r;
        logic r_valid;
    } resp_t;
endpackage

module axi_hier_throttle #(
    parameter int unsigned MaxTxns  = 8,
    parameter int unsigned CntWidth = $clog2(MaxTxns + 1),
    parameter type         req_t    = axi_hier_throttle_pkg::req_t,
    parameter type         resp_t   = axi_hier_throttle_pkg::resp_t
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  req_t                slv_req_i,
    output resp_t               slv_resp_o,
    output req_t                mst_req_o,
    input  resp_t               mst_resp_i,
    input  logic [CntWidth-1:0] wr_limit_i,
    input  logic [CntWidth-1:0] rd_limit_i,
    input  logic                block_i,
    output logic                idle_o,
    output logic [CntWidth-1:0] wr_outstanding_o,
    output logic [CntWidth-1:0] rd_outstanding_o
);
    localparam logic [CntWidth-1:0] MAX_CNT = CntWidth'(MaxTxns);

    logic [CntWidth-1:0] wr_lim, rd_lim;
    logic [CntWidth-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic                aw_hold_q, aw_hold_d, ar_hold_q, ar_hold_d;
    logic                idle_q, idle_d;
    logic                aw_allow, ar_allow;
    logic                aw_hs, ar_hs, b_hs, rlast_hs;

    function automatic logic [CntWidth-1:0] next_cnt(
        input logic [CntWidth-1:0] cnt,
        input logic                inc,
        input logic                dec
    );
        logic [CntWidth-1:0] res;
        res = cnt;
        if (inc && !dec && cnt != MAX_CNT) begin
            res = cnt + 1'b1;
        end else if (dec && !inc && cnt != '0) begin
            res = cnt - 1'b1;
        end
        return res;
    endfunction

    // Allow depends only on registers, block and limits: no ready->valid path.
    always_comb begin
        wr_lim   = (wr_limit_i == '0 || wr_limit_i > MAX_CNT) ? MAX_CNT : wr_limit_i;
        rd_lim   = (rd_limit_i == '0 || rd_limit_i > MAX_CNT) ? MAX_CNT : rd_limit_i;
        aw_allow = aw_hold_q | (~block_i & (wr_cnt_q < wr_lim));
        ar_allow = ar_hold_q | (~block_i & (rd_cnt_q < rd_lim));
    end

    always_comb begin
        mst_req_o           = slv_req_i;
        mst_req_o.aw_valid  = slv_req_i.aw_valid & aw_allow;
        mst_req_o.ar_valid  = slv_req_i.ar_valid & ar_allow;
        slv_resp_o          = mst_resp_i;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_allow;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_allow;
    end

    always_comb begin
        aw_hs     = slv_req_i.aw_valid & aw_allow & mst_resp_i.aw_ready;
        ar_hs     = slv_req_i.ar_valid & ar_allow & mst_resp_i.ar_ready;
        b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;
        rlast_hs  = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
        // A presented-but-unaccepted AX keeps its gate open until it completes.
        aw_hold_d = slv_req_i.aw_valid & aw_allow & ~mst_resp_i.aw_ready;
        ar_hold_d = slv_req_i.ar_valid & ar_allow & ~mst_resp_i.ar_ready;
        wr_cnt_d  = next_cnt(wr_cnt_q, aw_hs, b_hs);
        rd_cnt_d  = next_cnt(rd_cnt_q, ar_hs, rlast_hs);
        idle_d    = (wr_cnt_d == '0) && (rd_cnt_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            aw_hold_q <= 1'b0;
            ar_hold_q <= 1'b0;
            idle_q    <= 1'b1;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            aw_hold_q <= aw_hold_d;
            ar_hold_q <= ar_hold_d;
            idle_q    <= idle_d;
        end
    end

    assign idle_o           = idle_q;
    assign wr_outstanding_o = wr_cnt_q;
    assign rd_outstanding_o = rd_cnt_q;

`ifndef SYNTHESIS
    a_wr_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(b_hs && !aw_hs && wr_cnt_q == '0));
    a_rd_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rlast_hs && !ar_hs && rd_cnt_q == '0));
    a_wr_ceiling   : assert property (@(posedge clk_i) disable iff (!rst_ni)
        wr_cnt_q <= MAX_CNT);
    a_rd_ceiling   : assert property (@(posedge clk_i) disable iff (!rst_ni)
        rd_cnt_q <= MAX_CNT);
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_hier_throttle.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_hier_throttle
// Purpose  : Directed bench with a counting reference model for the throttle.
// Revision : 1.0 - initial release
// ============================================================================

module tb_axi_hier_throttle;
    import axi_hier_throttle_pkg::*;

    localparam int MAXT = 8;
    localparam int CW   = 4;

    logic          clk_i  = 1'b0;
    logic          rst_ni = 1'b0;
    req_t          slv_req, mst_req;
    resp_t         slv_resp, mst_resp;
    logic [CW-1:0] wr_limit, rd_limit, wr_out, rd_out;
    logic          block, idle;

    always #5 clk_i = ~clk_i;

    axi_hier_throttle #(.MaxTxns(MAXT)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .slv_req_i        (slv_req),
        .slv_resp_o       (slv_resp),
        .mst_req_o        (mst_req),
        .mst_resp_i       (mst_resp),
        .wr_limit_i       (wr_limit),
        .rd_limit_i       (rd_limit),
        .block_i          (block),
        .idle_o           (idle),
        .wr_outstanding_o (wr_out),
        .rd_outstanding_o (rd_out)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Environment: upstream AX source and downstream B/R responder.
    // ------------------------------------------------------------------
    int   cyc        = 0;
    int   aw_to_send = 0;
    int   ar_to_send = 0;
    logic aw_rdy_en  = 1'b1;
    int   b_delay    = 10;
    int   r_delay    = 20;
    int   aw_id      = 0;
    int   ar_id      = 0;
    int   r_beat     = 0;
    int   b_due[$], r_due[$];
    int   aw_log[$], ar_log[$], b_log[$], rlast_log[$];

    task automatic drive();
        slv_req            = '0;
        slv_req.aw_valid   = rst_ni && (aw_to_send > 0);
        slv_req.aw.id      = aw_id[3:0];
        slv_req.aw.addr    = 32'h1000 + 32'(aw_id) * 32'd16;
        slv_req.w_valid    = cyc[0];
        slv_req.w.data     = 32'(cyc) ^ 32'hA5A5_0000;
        slv_req.w.strb     = 4'hF;
        slv_req.w.last     = 1'b1;
        slv_req.b_ready    = 1'b1;
        slv_req.ar_valid   = rst_ni && (ar_to_send > 0);
        slv_req.ar.id      = ar_id[3:0];
        slv_req.ar.addr    = 32'h8000 + 32'(ar_id) * 32'd64;
        slv_req.ar.len     = 8'd3;
        slv_req.r_ready    = 1'b1;
        mst_resp           = '0;
        mst_resp.aw_ready  = aw_rdy_en;
        mst_resp.ar_ready  = 1'b1;
        mst_resp.w_ready   = cyc[1];
        mst_resp.b_valid   = (b_due.size() > 0) && (b_due[0] <= cyc);
        mst_resp.b.id      = 4'(cyc);
        mst_resp.r_valid   = (r_due.size() > 0) && (r_due[0] <= cyc);
        mst_resp.r.data    = 32'(cyc);
        mst_resp.r.last    = (r_beat == 3);
    endtask

    always begin : env
        logic aw_h, ar_h, b_h, r_h;
        @(negedge clk_i);
        aw_h = mst_req.aw_valid && mst_resp.aw_ready;
        ar_h = mst_req.ar_valid && mst_resp.ar_ready;
        b_h  = mst_resp.b_valid && slv_req.b_ready;
        r_h  = mst_resp.r_valid && slv_req.r_ready;
        @(posedge clk_i);
        #1;
        if (!rst_ni) begin
            aw_to_send = 0;
            ar_to_send = 0;
            r_beat     = 0;
            b_due.delete();
            r_due.delete();
        end else begin
            if (aw_h) begin
                aw_log.push_back(cyc);
                b_due.push_back(cyc + b_delay);
                aw_to_send--;
                aw_id++;
            end
            if (ar_h) begin
                ar_log.push_back(cyc);
                r_due.push_back(cyc + r_delay);
                ar_to_send--;
                ar_id++;
            end
            if (b_h) begin
                b_log.push_back(cyc);
                void'(b_due.pop_front());
            end
            if (r_h) begin
                if (r_beat == 3) begin
                    rlast_log.push_back(cyc);
                    void'(r_due.pop_front());
                    r_beat = 0;
                end else begin
                    r_beat++;
                end
            end
        end
        cyc++;
        drive();
    end

    // ------------------------------------------------------------------
    // Reference model: outstanding = starts - completions, per direction.
    // ------------------------------------------------------------------
    int  m_wr = 0, m_rd = 0;
    bit  m_aw_pend = 1'b0, m_ar_pend = 1'b0;
    ax_t m_aw_pl, m_ar_pl;

    function automatic int eff(input int l);
        return (l == 0 || l > MAXT) ? MAXT : l;
    endfunction

    always @(negedge clk_i) begin : chk
        bit aw_ok, ar_ok, exp_awv, exp_arv, b_h, rl_h;
        if (!rst_ni) begin
            m_wr      = 0;
            m_rd      = 0;
            m_aw_pend = 1'b0;
            m_ar_pend = 1'b0;
        end else begin
            aw_ok   = m_aw_pend || (!block && m_wr < eff(int'(wr_limit)));
            ar_ok   = m_ar_pend || (!block && m_rd < eff(int'(rd_limit)));
            exp_awv = slv_req.aw_valid && aw_ok;
            exp_arv = slv_req.ar_valid && ar_ok;
            check("mst_aw_valid", mst_req.aw_valid, exp_awv);
            check("slv_aw_ready", slv_resp.aw_ready, mst_resp.aw_ready && aw_ok);
            check("mst_ar_valid", mst_req.ar_valid, exp_arv);
            check("slv_ar_ready", slv_resp.ar_ready, mst_resp.ar_ready && ar_ok);
            check("wr_outstanding", wr_out, m_wr);
            check("rd_outstanding", rd_out, m_rd);
            check("idle", idle, (m_wr == 0) && (m_rd == 0));
            if (m_aw_pend) check("aw_payload_stable", mst_req.aw == m_aw_pl, 1);
            if (m_ar_pend) check("ar_payload_stable", mst_req.ar == m_ar_pl, 1);
            check("req_passthru",
                  {mst_req.aw, mst_req.w, mst_req.w_valid, mst_req.b_ready, mst_req.ar, mst_req.r_ready} ==
                  {slv_req.aw, slv_req.w, slv_req.w_valid, slv_req.b_ready, slv_req.ar, slv_req.r_ready}, 1);
            check("resp_passthru",
                  {slv_resp.w_ready, slv_resp.b, slv_resp.b_valid, slv_resp.r, slv_resp.r_valid} ==
                  {mst_resp.w_ready, mst_resp.b, mst_resp.b_valid, mst_resp.r, mst_resp.r_valid}, 1);
            b_h  = mst_resp.b_valid && slv_req.b_ready;
            rl_h = mst_resp.r_valid && slv_req.r_ready && mst_resp.r.last;
            m_wr = m_wr + int'(exp_awv && mst_resp.aw_ready) - int'(b_h);
            m_rd = m_rd + int'(exp_arv && mst_resp.ar_ready) - int'(rl_h);
            if (m_wr < 0) m_wr = 0;
            if (m_rd < 0) m_rd = 0;
            m_aw_pend = exp_awv && !mst_resp.aw_ready;
            m_ar_pend = exp_arv && !mst_resp.ar_ready;
            m_aw_pl   = slv_req.aw;
            m_ar_pl   = slv_req.ar;
        end
    end

    // ------------------------------------------------------------------
    // Directed scenarios with hand-computed expectations.
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while (!(idle && aw_to_send == 0 && ar_to_send == 0) && k < budget) begin
            step(1);
            k++;
        end
        check(name, k < budget, 1);
    endtask

    task automatic clear_logs();
        aw_log.delete();
        ar_log.delete();
        b_log.delete();
        rlast_log.delete();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin : stim
        int k;
        wr_limit = '0;
        rd_limit = '0;
        block    = 1'b0;
        drive();
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_idle", idle, 1);
        check("rst_wr_out", wr_out, 0);
        check("rst_rd_out", rd_out, 0);
        @(posedge clk_i);
        #2 rst_ni = 1'b1;
        step(2);

        // Limit 2, four writes, B delayed 10 cycles.
        wr_limit   = 4'd2;
        b_delay    = 10;
        aw_to_send = 4;
        step(6);
        check("s1_aw_count", aw_log.size(), 2);
        check("s1_wr_out", wr_out, 2);
        check("s1_slv_aw_ready", slv_resp.aw_ready, 0);
        k = 0;
        while (aw_log.size() < 3 && k < 40) begin step(1); k++; end
        if (aw_log.size() >= 3 && b_log.size() >= 1)
            check("s1_third_aw_after_b", aw_log[2] - b_log[0], 1);
        else
            check("s1_third_aw_seen", aw_log.size(), 3);
        wait_idle("s1_drain", 100);
        check("s1_total_b", b_log.size(), 4);
        clear_logs();
        wr_limit = '0;

        // Limit 0 (= MaxTxns), ten 4-beat reads.
        rd_limit   = '0;
        r_delay    = 20;
        ar_to_send = 10;
        step(14);
        check("s2_ar_count", ar_log.size(), 8);
        check("s2_rd_out", rd_out, 8);
        check("s2_slv_ar_ready", slv_resp.ar_ready, 0);
        k = 0;
        while (ar_log.size() < 9 && k < 40) begin step(1); k++; end
        if (ar_log.size() >= 9 && rlast_log.size() >= 1) begin
            check("s2_ninth_ar_after_rlast", ar_log[8] - rlast_log[0], 1);
            check("s2_rd_out_after_ninth", rd_out, 8);
        end else begin
            check("s2_ninth_ar_seen", ar_log.size(), 9);
        end
        wait_idle("s2_drain", 200);
        check("s2_total_rlast", rlast_log.size(), 10);
        clear_logs();

        // Block while an AW is stalled downstream.
        aw_rdy_en  = 1'b0;
        b_delay    = 4;
        aw_to_send = 1;
        step(3);
        check("s3_stalled_valid", mst_req.aw_valid, 1);
        block      = 1'b1;
        ar_to_send = 1;
        step(4);
        check("s3_held_valid", mst_req.aw_valid, 1);
        check("s3_held_id", mst_req.aw.id, 4);
        check("s3_held_addr", mst_req.aw.addr, 32'h1040);
        check("s3_no_ar", mst_req.ar_valid, 0);
        check("s3_no_ar_ready", slv_resp.ar_ready, 0);
        aw_rdy_en = 1'b1;
        k = 0;
        while (!(mst_resp.b_valid && slv_req.b_ready) && k < 40) begin
            @(negedge clk_i);
            k++;
        end
        check("s3_b_seen", k < 40, 1);
        check("s3_idle_at_b", idle, 0);
        @(negedge clk_i);
        check("s3_idle_after_b", idle, 1);
        check("s3_ar_still_blocked", ar_log.size(), 0);
        @(posedge clk_i);
        #2 block = 1'b0;
        wait_idle("s3_drain", 100);
        check("s3_ar_after_unblock", ar_log.size(), 1);
        clear_logs();

        // AW and B handshakes in the same cycle at count 3.
        wr_limit   = 4'd15;
        b_delay    = 3;
        aw_to_send = 4;
        k = 0;
        while (!(mst_req.aw_valid && mst_resp.aw_ready && mst_resp.b_valid && slv_req.b_ready) && k < 30) begin
            @(negedge clk_i);
            k++;
        end
        check("s4_simultaneous_seen", k < 30, 1);
        check("s4_cnt_before", wr_out, 3);
        @(negedge clk_i);
        check("s4_cnt_after", wr_out, 3);
        @(posedge clk_i);
        #2;
        wait_idle("s4_drain", 100);
        clear_logs();
        wr_limit = '0;

        // Read limit lowered with six reads outstanding.
        r_delay    = 30;
        ar_to_send = 6;
        step(10);
        check("s5_rd_out", rd_out, 6);
        rd_limit   = 4'd2;
        ar_to_send = 1;
        k = 0;
        while (!(mst_req.ar_valid && mst_resp.ar_ready) && k < 100) begin
            @(negedge clk_i);
            k++;
        end
        check("s5_ar_seen", k < 100, 1);
        check("s5_cnt_at_ar", rd_out, 1);
        @(posedge clk_i);
        #2;
        wait_idle("s5_drain", 200);
        rd_limit = '0;
        clear_logs();

        // Asynchronous reset mid-burst.
        b_delay    = 20;
        r_delay    = 20;
        aw_to_send = 4;
        ar_to_send = 4;
        step(7);
        check("s6_wr_busy", wr_out, 4);
        check("s6_rd_busy", rd_out, 4);
        @(posedge clk_i);
        #3 rst_ni = 1'b0;
        #1;
        check("s6_rst_wr", wr_out, 0);
        check("s6_rst_rd", rd_out, 0);
        check("s6_rst_idle", idle, 1);
        step(2);
        rst_ni = 1'b1;
        step(3);
        check("s6_post_idle", idle, 1);
        check("s6_post_wr", wr_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_hier_throttle.md
# axi_hier_throttle

Per-port AXI outstanding-transaction limiter on each master port of the hierarchical AXI interconnect, between the interconnect's ID remapper and the system-level crossbar/L2. Counts outstanding writes (AW to B) and reads (AR to last R) and stalls new AW/AR when a programmable limit is reached. A `block_i` quiesce input and an `idle_o` status let software drain the port before read-only cache flushes or reconfiguration. W, B and R payloads pass through unchanged with zero latency.

## Interface
- `MaxTxns`, 8: hardware ceiling on outstanding transactions per direction; must be ≥1.
- `CntWidth`, `$clog2(MaxTxns+1)`: width of counters and limit inputs; derived, do not override.
- `req_t`, logic: AXI request struct, identical on both sides.
- `resp_t`, logic: AXI response struct, identical on both sides.
- `clk_i` input 1: clock; all state on rising edge.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `slv_req_i` input req_t: request from the interconnect master port.
- `slv_resp_o` output resp_t: response to the interconnect.
- `mst_req_o` output req_t: request toward the system.
- `mst_resp_i` input resp_t: response from the system.
- `wr_limit_i` input CntWidth: write limit; 0 or >MaxTxns means MaxTxns.
- `rd_limit_i` input CntWidth: read limit; same encoding.
- `block_i` input 1: when high, no new AW/AR is started.
- `idle_o` output 1: registered; high when both counters are 0.
- `wr_outstanding_o` output CntWidth: registered write counter.
- `rd_outstanding_o` output CntWidth: registered read counter.

## Operation
- Effective limit: `lim = (limit_i == 0 || limit_i > MaxTxns) ? MaxTxns : limit_i`. Compute this separately for rd and wr.
- Write gate: `aw_allow = aw_hold | (!block_i & wr_cnt < wr_lim)`.
  - `mst_req_o.aw_valid = slv_req_i.aw_valid & aw_allow`.
  - `slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_allow`.
- `aw_hold` register:
  - Set when `mst_req_o.aw_valid & !mst_resp_i.aw_ready`.
  - Cleared on the AW handshake.
  - Guarantees AXI valid stability if `block_i` rises or the limit drops while an AW is presented.
- Read gate: identical, using AR, `ar_hold`, `rd_cnt` and `rd_lim`.
- All other request and response fields and channels pass through combinationally, unmodified.
  - W is not gated; W-before-AW is legal downstream.
- `wr_cnt`:
  - +1 on master-side AW handshake.
  - −1 on B handshake (`b_valid & b_ready`).
  - Both in the same cycle: unchanged.
- `rd_cnt`:
  - +1 on AR handshake.
  - −1 on R handshake with `r_last`.
  - Both in the same cycle: unchanged.
  - Non-last R beats do not change the count.
- Underflow (decrement at 0 with no increment): counter holds 0; simulation assertion fires.
- Counter never exceeds MaxTxns; assert it.
- Lowering a limit below the current count blocks new starts until the count drains below the new limit. In-flight transactions are unaffected.
- `block_i` does not affect B/R or W; outstanding transactions complete normally.

## Timing
- Reset values:
  - Counters and hold flags: 0.
  - `idle_o`: 1; `wr_outstanding_o` and `rd_outstanding_o`: 0.
  - Forwarded valids/readies follow inputs combinationally, gated by reset-state allow (limit >0 and `!block_i`).
- Pass-through latency: 0 cycles on all channels.
- `aw_allow`/`ar_allow` depend only on registers, `block_i` and limits. There is no combinational path from `aw_ready` to `aw_valid`.
- Counter update is visible the cycle after the handshake.
  - With limit 1: AW accepted in cycle t, B handshake in cycle t+k, next AW may handshake earliest at t+k+1.
- `idle_o` asserts the cycle after the last decrementing handshake. It deasserts the cycle after any AW/AR handshake.
- `block_i` takes effect in the same cycle for any AX not yet presented. An already-presented AX (hold set) completes.
- Reset mid-operation clears all state immediately (asynchronous). The system side must be reset together.

## Test plan
- **Limit 2, writes:** `wr_limit_i=2`, 4 back-to-back AWs, B delayed 10 cycles.
  - Required: exactly 2 AW handshakes, then `slv aw_ready` held low with `wr_outstanding_o=2`.
  - Required: third AW accepted 1 cycle after the first B.
- **Limit 0 and read bursts:** `rd_limit_i=0`, MaxTxns=8, ten 4-beat reads.
  - Required: 8 ARs accepted; count decrements only on `r_last`.
  - Required: 9th AR accepted the cycle after the first `r_last` handshake.
- **Block with AW stalled:** assert `block_i` while `mst aw_valid=1` and `aw_ready=0`.
  - Required: AW stays valid with stable payload until accepted; no further AW/AR start.
  - Required: `idle_o` rises 1 cycle after the final B.
- **Simultaneous events:** with `wr_cnt=3`, AW handshake and B handshake in the same cycle.
  - Required: `wr_outstanding_o` stays 3.
- **Limit lowered in flight:** 6 reads outstanding, `rd_limit_i` changed to 2.
  - Required: no AR accepted until the count reaches 1; then one AR accepted.
- **Async reset:** `rst_ni` low mid-burst.
  - Required: counters 0 and `idle_o=1` without waiting for a clock edge; assertions quiet.
